noc_node_bridge: RTL and testbench

- Parametrised NOC endpoint bridge replacing fixed 8-bit addr / 32-bit data PIO pairs with buffered, handshaked channels.
- Sits between a processor-side master (ReCOP or the Nios PIO layer) and one TDM NOC port.
- TX: FIFO-buffered words are presented to the NOC with valid/ack.
- RX: words are filtered by node ID or broadcast, buffered, and counted when dropped.

---
 rtl/noc_node_bridge.sv | 125 ++++++++++++
 tb/tb_noc_node_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_node_bridge.sv
// NOC endpoint bridge: a buffered TX channel with valid/ack toward the NOC, and a
// node-ID/broadcast filtered RX FIFO with a saturating counter for words dropped while full.
module noc_node_bridge #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       TX_DEPTH = 4,
    parameter int unsigned       RX_DEPTH = 4,
    parameter logic [ADDR_W-1:0] NODE_ID  = '0
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic [ADDR_W-1:0]         tx_addr,
    input  logic [DATA_W-1:0]         tx_data,
    output logic                      noc_valid_out,
    input  logic                      noc_ack_in,
    output logic [ADDR_W-1:0]         noc_addr_out,
    output logic [DATA_W-1:0]         noc_data_out,
    input  logic                      noc_valid_in,
    input  logic [ADDR_W-1:0]         noc_addr_in,
    input  logic [DATA_W-1:0]         noc_data_in,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic [ADDR_W-1:0]         rx_addr,
    output logic [DATA_W-1:0]         rx_data,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [7:0]                rx_drop_cnt
);
    localparam int unsigned TPW = $clog2(TX_DEPTH);
    localparam int unsigned RPW = $clog2(RX_DEPTH);
    localparam int unsigned WW  = ADDR_W + DATA_W;
    localparam logic [TPW:0] TX_FULL = (TPW + 1)'(TX_DEPTH);
    localparam logic [RPW:0] RX_FULL = (RPW + 1)'(RX_DEPTH);

    typedef enum logic {StIdle, StSend} state_t;

    logic [WW-1:0]  tx_mem [TX_DEPTH];
    logic [TPW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic           tx_push, tx_pop;
    state_t         state;

    logic [WW-1:0]  rx_mem [RX_DEPTH];
    logic [RPW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic           rx_match, rx_full, rx_wr, rx_drop, rx_pop;

    // ---------------- TX path ----------------
    assign tx_ready = (tx_count != TX_FULL);
    assign tx_push  = tx_valid && tx_ready;
    // Pop when idle with data, or on ack while another word is waiting (back-to-back).
    assign tx_pop   = (tx_count != '0) && ((state == StIdle) || noc_ack_in);

    always_ff @(posedge clk_clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= {tx_addr, tx_data};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_wr_ptr     <= '0;
            tx_rd_ptr     <= '0;
            tx_count      <= '0;
            state         <= StIdle;
            noc_valid_out <= 1'b0;
            noc_addr_out  <= '0;
            noc_data_out  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + TPW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TPW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
            else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;

            case (state)
                StIdle: begin
                    if (tx_pop) begin
                        {noc_addr_out, noc_data_out} <= tx_mem[tx_rd_ptr];
                        noc_valid_out                <= 1'b1;
                        state                        <= StSend;
                    end
                end
                StSend: begin
                    if (noc_ack_in) begin
                        if (tx_pop) begin
                            {noc_addr_out, noc_data_out} <= tx_mem[tx_rd_ptr];
                        end else begin
                            noc_valid_out <= 1'b0;
                            state         <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // ---------------- RX path ----------------
    assign rx_match = noc_valid_in && ((noc_addr_in == NODE_ID) || (noc_addr_in == '1));
    assign rx_full  = (rx_count == RX_FULL);
    // Fullness is judged before the edge, so a same-edge pop does not rescue the word.
    assign rx_wr    = rx_match && !rx_full;
    assign rx_drop  = rx_match && rx_full;
    assign rx_valid = (rx_count != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign {rx_addr, rx_data} = rx_mem[rx_rd_ptr];

    always_ff @(posedge clk_clk) begin
        if (rx_wr) rx_mem[rx_wr_ptr] <= {noc_addr_in, noc_data_in};
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
            rx_count    <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (rx_wr)  rx_wr_ptr <= rx_wr_ptr + RPW'(1);
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + RPW'(1);
            if (rx_wr && !rx_pop)      rx_count <= rx_count + 1'b1;
            else if (!rx_wr && rx_pop) rx_count <= rx_count - 1'b1;
            if (rx_drop && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_node_bridge.sv
// Directed bench for noc_node_bridge: RX vector table plus hand-written TX and reset sequences.
module tb_noc_node_bridge;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_addr;
    logic [31:0] tx_data;
    logic        noc_valid_out, noc_ack_in;
    logic [7:0]  noc_addr_out;
    logic [31:0] noc_data_out;
    logic        noc_valid_in;
    logic [7:0]  noc_addr_in;
    logic [31:0] noc_data_in;
    logic        rx_valid, rx_ready;
    logic [7:0]  rx_addr;
    logic [31:0] rx_data;
    logic [2:0]  tx_count, rx_count;
    logic [7:0]  rx_drop_cnt;

    int checks = 0;
    int errors = 0;

    noc_node_bridge #(
        .DATA_W(32), .ADDR_W(8), .TX_DEPTH(4), .RX_DEPTH(4), .NODE_ID(8'h03)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_addr(tx_addr), .tx_data(tx_data),
        .noc_valid_out(noc_valid_out), .noc_ack_in(noc_ack_in),
        .noc_addr_out(noc_addr_out), .noc_data_out(noc_data_out),
        .noc_valid_in(noc_valid_in), .noc_addr_in(noc_addr_in), .noc_data_in(noc_data_in),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_addr(rx_addr), .rx_data(rx_data),
        .tx_count(tx_count), .rx_count(rx_count), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic        vin;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        rdy;
        logic [2:0]  e_cnt;
        logic        e_valid;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic [7:0]  e_drop;
    } rx_vec_t;

    rx_vec_t vecs [15];
    logic [7:0]  w_addr [5];
    logic [31:0] w_data [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        tick();
        tick();
        reset_reset_n = 1'b1;
        tick();
    endtask

    initial begin
        // RX table: inputs for one edge, expected state after it (NODE_ID=3, depth 4)
        vecs[0]  = '{1'b1, 8'h03, 32'hA1, 1'b0, 3'd1, 1'b1, 8'h03, 32'hA1, 8'd0};
        vecs[1]  = '{1'b1, 8'hFF, 32'hA2, 1'b0, 3'd2, 1'b1, 8'h03, 32'hA1, 8'd0};
        vecs[2]  = '{1'b1, 8'h05, 32'hA3, 1'b0, 3'd2, 1'b1, 8'h03, 32'hA1, 8'd0};
        vecs[3]  = '{1'b0, 8'h00, 32'h0,  1'b1, 3'd1, 1'b1, 8'hFF, 32'hA2, 8'd0};
        vecs[4]  = '{1'b0, 8'h00, 32'h0,  1'b1, 3'd0, 1'b0, 8'h00, 32'h0,  8'd0};
        vecs[5]  = '{1'b0, 8'h00, 32'h0,  1'b1, 3'd0, 1'b0, 8'h00, 32'h0,  8'd0};
        vecs[6]  = '{1'b1, 8'h03, 32'hB0, 1'b0, 3'd1, 1'b1, 8'h03, 32'hB0, 8'd0};
        vecs[7]  = '{1'b1, 8'hFF, 32'hB1, 1'b0, 3'd2, 1'b1, 8'h03, 32'hB0, 8'd0};
        vecs[8]  = '{1'b1, 8'h03, 32'hB2, 1'b0, 3'd3, 1'b1, 8'h03, 32'hB0, 8'd0};
        vecs[9]  = '{1'b1, 8'h03, 32'hB3, 1'b0, 3'd4, 1'b1, 8'h03, 32'hB0, 8'd0};
        vecs[10] = '{1'b1, 8'h03, 32'hC0, 1'b0, 3'd4, 1'b1, 8'h03, 32'hB0, 8'd1};
        vecs[11] = '{1'b1, 8'hFF, 32'hC1, 1'b0, 3'd4, 1'b1, 8'h03, 32'hB0, 8'd2};
        vecs[12] = '{1'b1, 8'h03, 32'hC2, 1'b1, 3'd3, 1'b1, 8'hFF, 32'hB1, 8'd3};
        vecs[13] = '{1'b1, 8'h05, 32'hD0, 1'b1, 3'd2, 1'b1, 8'h03, 32'hB2, 8'd3};
        vecs[14] = '{1'b1, 8'h03, 32'hD1, 1'b1, 3'd2, 1'b1, 8'h03, 32'hB3, 8'd3};
        for (int i = 0; i < 5; i++) begin
            w_addr[i] = 8'h20 + 8'(i);
            w_data[i] = 32'h1000_0000 + 32'(i);
        end

        tx_valid = 0; tx_addr = 0; tx_data = 0; noc_ack_in = 0;
        noc_valid_in = 0; noc_addr_in = 0; noc_data_in = 0; rx_ready = 0;
        reset_reset_n = 1'b0;
        #12;
        check("rst_noc_valid", noc_valid_out, 0);
        check("rst_noc_addr", noc_addr_out, 0);
        check("rst_noc_data", noc_data_out, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_drop", rx_drop_cnt, 0);
        reset_reset_n = 1'b1;
        tick();

        // Ack while idle must be ignored
        noc_ack_in = 1; tick(); noc_ack_in = 0;
        check("idle_ack_valid", noc_valid_out, 0);

        // Single word latency and hold
        tx_valid = 1; tx_addr = 8'h11; tx_data = 32'hDEADBEEF;
        tick();
        tx_valid = 0;
        check("lat_edge1_valid", noc_valid_out, 0);
        check("lat_edge1_count", tx_count, 1);
        tick();
        check("lat_edge2_valid", noc_valid_out, 1);
        check("lat_edge2_count", tx_count, 0);
        for (int i = 0; i < 10; i++) begin
            check("hold_addr", noc_addr_out, 8'h11);
            check("hold_data", noc_data_out, 32'hDEADBEEF);
            check("hold_valid", noc_valid_out, 1);
            tick();
        end
        noc_ack_in = 1; tick(); noc_ack_in = 0;
        check("ack_valid", noc_valid_out, 0);
        check("ack_count", tx_count, 0);
        check("ack_data_hold", noc_data_out, 32'hDEADBEEF);

        // Fill: five pushes with ack low, the first is absorbed by the output register
        for (int i = 0; i < 5; i++) begin
            tx_valid = 1; tx_addr = w_addr[i]; tx_data = w_data[i];
            tick();
            check("fill_count", tx_count, (i == 0) ? 1 : i);
        end
        check("full_ready", tx_ready, 0);
        tx_addr = 8'h77; tx_data = 32'h77;
        tick();
        tx_valid = 0;
        check("reject_count", tx_count, 4);
        check("reject_out_addr", noc_addr_out, w_addr[0]);
        noc_ack_in = 1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", noc_valid_out, 1);
            check("drain_addr", noc_addr_out, w_addr[i]);
            check("drain_data", noc_data_out, w_data[i]);
            tick();
        end
        noc_ack_in = 0;
        check("drain_end_valid", noc_valid_out, 0);
        check("drain_end_count", tx_count, 0);

        // RX vector table
        for (int i = 0; i < 15; i++) begin
            noc_valid_in = vecs[i].vin; noc_addr_in = vecs[i].addr;
            noc_data_in = vecs[i].data; rx_ready = vecs[i].rdy;
            tick();
            check($sformatf("rx%0d_count", i), rx_count, vecs[i].e_cnt);
            check($sformatf("rx%0d_valid", i), rx_valid, vecs[i].e_valid);
            check($sformatf("rx%0d_drop", i), rx_drop_cnt, vecs[i].e_drop);
            if (vecs[i].e_valid) begin
                check($sformatf("rx%0d_addr", i), rx_addr, vecs[i].e_addr);
                check($sformatf("rx%0d_data", i), rx_data, vecs[i].e_data);
            end
        end
        noc_valid_in = 0; rx_ready = 0;

        // Drop counter saturation
        do_reset();
        check("sat_pre_drop", rx_drop_cnt, 0);
        noc_valid_in = 1; noc_addr_in = 8'h03;
        for (int i = 0; i < 304; i++) begin
            noc_data_in = 32'(i);
            tick();
        end
        noc_valid_in = 0;
        check("sat_drop", rx_drop_cnt, 255);
        check("sat_count", rx_count, 4);
        check("sat_head", rx_data, 0);

        // Asynchronous reset mid-SEND with both FIFOs part-full
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1; tx_addr = w_addr[i]; tx_data = w_data[i];
            noc_valid_in = 1; noc_addr_in = 8'hFF; noc_data_in = w_data[i];
            tick();
        end
        tx_valid = 0; noc_valid_in = 0;
        check("pre_rst_valid", noc_valid_out, 1);
        check("pre_rst_txcnt", tx_count, 2);
        check("pre_rst_rxcnt", rx_count, 3);
        reset_reset_n = 1'b0;
        #2;
        check("async_valid", noc_valid_out, 0);
        check("async_txcnt", tx_count, 0);
        check("async_rxcnt", rx_count, 0);
        check("async_rx_valid", rx_valid, 0);
        check("async_tx_ready", tx_ready, 1);
        tick();
        reset_reset_n = 1'b1;
        tick();
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_valid", noc_valid_out, 0);
        check("post_rst_txcnt", tx_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
